// File: rtl/lsu_align_ctrl.sv
// Load/store initiator: splits misaligned CPU accesses into word-aligned memory
// accesses with byte-lane enables, then aligns and extends the returned load data.
module lsu_align_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rd,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic [3:0]            mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // IDLE accepts, ISSUE0 first word, ISSUE1 second word of a split, DONE responds
    typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, DONE} state_t;

    localparam logic [DM_ADDRESS-3:0] WORD_ONE = 1;

    state_t                  state_q, state_d;
    logic [DM_ADDRESS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wd_q, wd_d;
    logic [2:0]              f3_q, f3_d;
    logic                    load_q, load_d;
    logic [DATA_W-1:0]       lo_q, lo_d;
    logic [DATA_W-1:0]       rd_q, rd_d;

    logic [1:0]              offset;
    logic [2:0]              size;
    logic [2:0]              inv_off;
    logic                    split;
    logic [3:0]              lane_mask;
    logic [DM_ADDRESS-3:0]   word_next;
    logic [DM_ADDRESS-1:0]   w0, w1;
    logic [DATA_W-1:0]       hi, lo, raw, ext;

    always_comb begin
        offset = addr_q[1:0];
        case (f3_q[1:0])
            2'b00:   begin size = 3'd1; lane_mask = 4'b0001; end
            2'b01:   begin size = 3'd2; lane_mask = 4'b0011; end
            default: begin size = 3'd4; lane_mask = 4'b1111; end
        endcase
        split     = ({1'b0, offset} + size) > 3'd4;
        inv_off   = 3'd4 - {1'b0, offset};
        word_next = addr_q[DM_ADDRESS-1:2] + WORD_ONE;
        w0        = {addr_q[DM_ADDRESS-1:2], 2'b00};
        w1        = {word_next, 2'b00};

        // Aligned accesses see their only word as lo; split ones get hi in DONE
        hi  = split ? mem_rdata : '0;
        lo  = split ? lo_q : mem_rdata;
        raw = DATA_W'({hi, lo} >> {offset, 3'b000});
        case (f3_q)
            3'b000:  ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
            3'b100:  ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
            3'b001:  ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            3'b101:  ext = {{(DATA_W-16){1'b0}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        f3_d      = f3_q;
        load_d    = load_q;
        lo_d      = lo_q;
        rd_d      = rd_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rd        = rd_q;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_wr    = 4'b0000;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (MemRead || MemWrite)) begin
                    addr_d  = a;
                    wd_d    = wd;
                    f3_d    = Funct3;
                    load_d  = MemRead;
                    state_d = ISSUE0;
                end
            end
            ISSUE0: begin
                mem_addr = w0;
                if (load_q) begin
                    mem_re = 1'b1;
                end else begin
                    mem_wr    = lane_mask << offset;
                    mem_wdata = wd_q << {offset, 3'b000};
                end
                state_d = split ? ISSUE1 : DONE;
            end
            ISSUE1: begin
                mem_addr = w1;
                if (load_q) begin
                    mem_re = 1'b1;
                    lo_d   = mem_rdata;
                end else begin
                    mem_wr    = lane_mask >> inv_off;
                    mem_wdata = wd_q >> {inv_off, 3'b000};
                end
                state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (load_q) begin
                    rd   = ext;
                    rd_d = ext;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            lo_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
        end
    end

endmodule
